// File: rtl/fidget_pattern_sched_pkg.sv
// -----------------------------------------------------------------------------
// fidget_pkg
// Shared types and constants for the fidget display blocks.
//   sched_state_t : scheduler FSM states (S_RUN drives a pattern, S_BLANK
//                   holds the display dark between patterns)
//   SEG_BLANK     : all segments off (active-low)
//   AN_OFF        : all anodes off (active-low)
// -----------------------------------------------------------------------------
package fidget_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_BLANK = 1'b1
    } sched_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/fidget_pattern_sched_tick_gen.sv
// -----------------------------------------------------------------------------
// fidget_tick_gen
// Free-running prescaler: counts 0..TICK_DIV-1 and wraps. tick is high for the
// single cycle in which the count sits at TICK_DIV-1.
// Ports:
//   CLK  in   system clock
//   RST  in   asynchronous active-high reset (count returns to 0)
//   tick out  one-cycle pulse every TICK_DIV cycles
// -----------------------------------------------------------------------------
module fidget_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/fidget_pattern_sched.sv
// -----------------------------------------------------------------------------
// fidget_pattern_sched
// Shares one 4-digit seven-segment display between NUM_PAT pattern generators.
// Generates the step tick for the selected pattern, muxes its seg/an onto the
// pins (registered), and advances to the next pattern on a button press or
// after DWELL_STEPS ticks when AUTO is set. Every switch blanks the display
// for BLANK_CYCLES cycles, during which the patterns receive no steps.
//
// Ports:
//   CLK       in   system clock
//   RST       in   asynchronous active-high reset
//   BTN       in   raw push button, rising edge = advance
//   AUTO      in   1 = auto-advance after the dwell time
//   pat_seg   in   segment bus, pattern i at [8i+7:8i], active-low
//   pat_an    in   anode bus, pattern i at [4i+3:4i], active-low
//   pat_step  out  one-hot one-cycle step enable to the selected pattern
//   seg       out  registered display segments, active-low
//   an        out  registered display anodes, active-low
//   mode      out  index of the selected pattern
//   dbg_state out  scheduler state (0 = S_RUN, 1 = S_BLANK)
//
// Step protocol: a pattern advances exactly one step in each cycle its
// pat_step bit is 1 and holds its state otherwise; there is no back-pressure.
//
// Build option: define FIDGET_SCHED_DEBOUNCE_EN to require BTN to be stable
// for DEBOUNCE_CYCLES cycles before its edge is recognised.
// -----------------------------------------------------------------------------
module fidget_pattern_sched
    import fidget_pkg::*;
#(
    parameter int NUM_PAT         = 4,
    parameter int TICK_DIV        = 25_000_000,
    parameter int DWELL_STEPS     = 28,
    parameter int BLANK_CYCLES    = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    localparam int MW             = $clog2(NUM_PAT)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 BTN,
    input  logic                 AUTO,
    input  logic [8*NUM_PAT-1:0] pat_seg,
    input  logic [4*NUM_PAT-1:0] pat_an,
    output logic [NUM_PAT-1:0]   pat_step,
    output logic [7:0]           seg,
    output logic [3:0]           an,
    output logic [MW-1:0]        mode,
    output logic                 dbg_state
);

    localparam int DW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_STEPS - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_PAT - 1);

    sched_state_t  r_state;
    logic [MW-1:0] r_mode;
    logic [7:0]    r_seg;
    logic [3:0]    r_an;
    logic [DW-1:0] r_dwell;
    logic [BW-1:0] r_blank;

    logic               w_tick;
    logic               w_auto_req;
    logic               w_adv_req;
    logic [MW-1:0]      w_mode_next;
    logic [7:0]         w_sel_seg;
    logic [3:0]         w_sel_an;
    logic [NUM_PAT-1:0] w_step;

    fidget_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .tick (w_tick)
    );

    // ---------------- button path ----------------
    logic r_btn_s1;
    logic r_btn_s2;
    logic r_btn_prev;
    logic w_btn_lvl;
    logic w_btn_req;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_s1   <= BTN;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= w_btn_lvl;
        end
    end

`ifdef FIDGET_SCHED_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic           r_db_lvl;
    logic [DBW-1:0] r_db_cnt;

    // The count restarts whenever the synchronized input agrees with the
    // accepted level, so only an unbroken run of the new level is accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_db_lvl <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_btn_s2 == r_db_lvl) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_lvl <= r_btn_s2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_btn_lvl = r_db_lvl;
`else
    assign w_btn_lvl = r_btn_s2;

    // Debounce length only matters when the debouncer is built in.
    logic w_unused_debounce;
    assign w_unused_debounce = (DEBOUNCE_CYCLES > 0);
`endif

    assign w_btn_req = w_btn_lvl & ~r_btn_prev;

    // ---------------- advance request ----------------
    assign w_auto_req  = w_tick & AUTO & (r_dwell == DWELL_LAST);
    // Both sources OR into one request, so coincident events advance once.
    assign w_adv_req   = w_btn_req | w_auto_req;
    assign w_mode_next = (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;

    // ---------------- pattern mux and step enable ----------------
    always_comb begin
        w_sel_seg = SEG_BLANK;
        w_sel_an  = AN_OFF;
        for (int i = 0; i < NUM_PAT; i++) begin
            if (r_mode == MW'(i)) begin
                w_sel_seg = pat_seg[8*i +: 8];
                w_sel_an  = pat_an[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_step = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            w_step[i] = (r_state == S_RUN) && w_tick && (r_mode == MW'(i));
        end
    end

    // ---------------- scheduler FSM ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_RUN;
            r_mode  <= '0;
            r_seg   <= SEG_BLANK;
            r_an    <= AN_OFF;
            r_dwell <= '0;
            r_blank <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_seg <= w_sel_seg;
                    r_an  <= w_sel_an;
                    if (w_adv_req) begin
                        r_mode  <= w_mode_next;
                        r_dwell <= '0;
                        r_blank <= '0;
                        r_state <= S_BLANK;
                    end else if (w_tick && AUTO) begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                S_BLANK: begin
                    // Requests arriving here are dropped on purpose.
                    r_seg <= SEG_BLANK;
                    r_an  <= AN_OFF;
                    if (r_blank == BLANK_LAST) begin
                        r_blank <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_blank <= r_blank + 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign pat_step  = w_step;
    assign seg       = r_seg;
    assign an        = r_an;
    assign mode      = r_mode;
    assign dbg_state = (r_state == S_BLANK);

endmodule

// File: tb/tb_fidget_pattern_sched.sv
// -----------------------------------------------------------------------------
// tb_fidget_pattern_sched
// Directed bench for fidget_pattern_sched with NUM_PAT=3, TICK_DIV=4,
// DWELL_STEPS=3, BLANK_CYCLES=2, DEBOUNCE_CYCLES=3. Inputs change on the
// falling edge and outputs are sampled there too. Cycle index n counts rising
// edges since reset release; the prescaler ticks in cycles with n%4==3.
// -----------------------------------------------------------------------------
module tb_fidget_pattern_sched;

    localparam int NUM_PAT = 3;

    localparam logic [23:0] PSEG = {8'h1F, 8'h3F, 8'h7F};
    localparam logic [11:0] PAN  = {4'hB, 4'hD, 4'hE};

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic                 BTN = 1'b0;
    logic                 AUTO = 1'b0;
    logic [8*NUM_PAT-1:0] pat_seg = PSEG;
    logic [4*NUM_PAT-1:0] pat_an = PAN;
    logic [NUM_PAT-1:0]   pat_step;
    logic [7:0]           seg;
    logic [3:0]           an;
    logic [1:0]           mode;
    logic                 dbg_state;

    int checks   = 0;
    int failures = 0;

    fidget_pattern_sched #(
        .NUM_PAT         (3),
        .TICK_DIV        (4),
        .DWELL_STEPS     (3),
        .BLANK_CYCLES    (2),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN       (BTN),
        .AUTO      (AUTO),
        .pat_seg   (pat_seg),
        .pat_an    (pat_an),
        .pat_step  (pat_step),
        .seg       (seg),
        .an        (an),
        .mode      (mode),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    // Leaves the bench at the falling edge right after reset release (n=0).
    task automatic do_reset();
        @(negedge CLK);
        RST  = 1'b1;
        BTN  = 1'b0;
        AUTO = 1'b0;
        pat_seg = PSEG;
        pat_an  = PAN;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [2:0] step_e;
        #1 RST = 1'b1;
        cyc();
        checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", seg); end
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", an); end
        checks++; if (pat_step !== 3'b000) begin failures++; $display("FAIL reset_step got=%b exp=000", pat_step); end
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
        RST = 1'b0;
        #1;
        checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL first_cycle_seg got=%h exp=ff", seg); end
        for (int n = 1; n <= 8; n++) begin
            cyc();
            step_e = (n == 3 || n == 7) ? 3'b001 : 3'b000;
            checks++; if (pat_step !== step_e) begin failures++; $display("FAIL run_step n=%0d got=%b exp=%b", n, pat_step, step_e); end
            checks++; if (mode !== 2'd0) begin failures++; $display("FAIL run_mode n=%0d got=%0d exp=0", n, mode); end
            if (n == 1) begin
                checks++; if (seg !== 8'h7F) begin failures++; $display("FAIL run_seg n=1 got=%h exp=7f", seg); end
                checks++; if (an !== 4'hE) begin failures++; $display("FAIL run_an n=1 got=%h exp=e", an); end
            end
            if (n == 5) begin
                checks++; if (seg !== 8'h6D) begin failures++; $display("FAIL seg_follow got=%h exp=6d", seg); end
            end
            if (n == 4) pat_seg[7:0] = 8'h6D;
        end
        pat_seg = PSEG;
    endtask

    task automatic test_button();
        logic [7:0] seg_e;
        logic [3:0] an_e;
        logic [2:0] step_e;
        logic [1:0] mode_e;
        do_reset();
        BTN = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            cyc();
            mode_e = (n >= 3) ? 2'd1 : 2'd0;
            seg_e  = (n <= 3) ? 8'h7F : (n <= 5) ? 8'hFF : 8'h3F;
            an_e   = (n <= 3) ? 4'hE  : (n <= 5) ? 4'hF  : 4'hD;
            step_e = (n == 7) ? 3'b010 : 3'b000;
            checks++; if (mode !== mode_e) begin failures++; $display("FAIL btn_mode n=%0d got=%0d exp=%0d", n, mode, mode_e); end
            checks++; if (seg !== seg_e) begin failures++; $display("FAIL btn_seg n=%0d got=%h exp=%h", n, seg, seg_e); end
            checks++; if (an !== an_e) begin failures++; $display("FAIL btn_an n=%0d got=%h exp=%h", n, an, an_e); end
            checks++; if (pat_step !== step_e) begin failures++; $display("FAIL btn_step n=%0d got=%b exp=%b", n, pat_step, step_e); end
        end
        BTN = 1'b0;
    endtask

    task automatic test_auto();
        logic [1:0] mode_e;
        logic [2:0] step_e;
        logic       blank_e;
        do_reset();
        AUTO = 1'b1;
        for (int n = 1; n <= 38; n++) begin
            cyc();
            mode_e  = (n < 12) ? 2'd0 : (n < 24) ? 2'd1 : (n < 36) ? 2'd2 : 2'd0;
            blank_e = (n == 12 || n == 13 || n == 24 || n == 25 || n == 36 || n == 37);
            step_e  = ((n % 4 == 3) && !blank_e) ? (3'b001 << mode_e) : 3'b000;
            checks++; if (mode !== mode_e) begin failures++; $display("FAIL auto_mode n=%0d got=%0d exp=%0d", n, mode, mode_e); end
            checks++; if (pat_step !== step_e) begin failures++; $display("FAIL auto_step n=%0d got=%b exp=%b", n, pat_step, step_e); end
            checks++; if (dbg_state !== blank_e) begin failures++; $display("FAIL auto_state n=%0d got=%b exp=%b", n, dbg_state, blank_e); end
        end
        AUTO = 1'b0;
    endtask

    task automatic test_dwell_hold();
        logic [1:0] mode_e;
        do_reset();
        AUTO = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            cyc();
            mode_e = (n >= 20) ? 2'd1 : 2'd0;
            checks++; if (mode !== mode_e) begin failures++; $display("FAIL dwell_hold_mode n=%0d got=%0d exp=%0d", n, mode, mode_e); end
            if (n == 8)  AUTO = 1'b0;
            if (n == 16) AUTO = 1'b1;
        end
        AUTO = 1'b0;
    endtask

`ifndef FIDGET_SCHED_DEBOUNCE_EN
    task automatic test_back_to_back();
        logic [1:0] mode_e;
        do_reset();
        AUTO = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            cyc();
            mode_e = (n < 12) ? 2'd0 : 2'd1;
            checks++; if (mode !== mode_e) begin failures++; $display("FAIL coincide_mode n=%0d got=%0d exp=%0d", n, mode, mode_e); end
            // First edge lands with auto_req (cycle 11), second inside the blank (cycle 13).
            if (n == 9)  BTN = 1'b1;
            if (n == 10) BTN = 1'b0;
            if (n == 11) BTN = 1'b1;
            if (n == 12) BTN = 1'b0;
        end
        AUTO = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_blank();
        bit found;
        do_reset();
        BTN = 1'b1;
        repeat (6) cyc();
        BTN = 1'b0;
        repeat (6) cyc();
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL midblank_first_press got=%0d exp=1", mode); end
        BTN = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (dbg_state === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL midblank_wait got=no_blank exp=blank_within_20"); end
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL midblank_mode got=%0d exp=2", mode); end
        RST = 1'b1;
        #1;
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL midblank_rst_mode got=%0d exp=0", mode); end
        checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL midblank_rst_seg got=%h exp=ff", seg); end
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL midblank_rst_an got=%h exp=f", an); end
        checks++; if (pat_step !== 3'b000) begin failures++; $display("FAIL midblank_rst_step got=%b exp=000", pat_step); end
        checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL midblank_rst_state got=%b exp=0", dbg_state); end
        BTN = 1'b0;
        cyc();
        RST = 1'b0;
        cyc();
        checks++; if (seg !== 8'h7F) begin failures++; $display("FAIL resume_seg got=%h exp=7f", seg); end
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL resume_mode got=%0d exp=0", mode); end
        cyc();
        cyc();
        checks++; if (pat_step !== 3'b001) begin failures++; $display("FAIL resume_step got=%b exp=001", pat_step); end
    endtask

    task automatic test_glitch();
        do_reset();
        BTN = 1'b1;
        cyc();
        cyc();
        BTN = 1'b0;
        repeat (8) cyc();
`ifdef FIDGET_SCHED_DEBOUNCE_EN
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL glitch_mode got=%0d exp=0", mode); end
        BTN = 1'b1;
        repeat (5) cyc();
        BTN = 1'b0;
        repeat (10) cyc();
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL press5_mode got=%0d exp=1", mode); end
`else
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL glitch_mode got=%0d exp=1", mode); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_button();
        test_auto();
        test_dwell_hold();
`ifndef FIDGET_SCHED_DEBOUNCE_EN
        test_back_to_back();
`endif
        test_reset_mid_blank();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fidget_pattern_sched.md
Name: fidget_pattern_sched

Overview:
Scheduler that shares the 4-digit seven-segment display between NUM_PAT pattern generators.
- Generates the step tick that advances the selected pattern FSM.
- Selects which pattern drives seg/an.
- Advances to the next pattern on a button press, or automatically after a dwell time.
- Blanks the display briefly on every switch.
- Sits between the pattern FSMs and the board seg/an pins.

Parameters:
NUM_PAT, 4, number of pattern sources (≥2)
TICK_DIV, 25_000_000, CLK cycles per pattern step tick
DWELL_STEPS, 28, step ticks spent on a pattern before auto-advance
BLANK_CYCLES, 1_000_000, CLK cycles of blank display after a switch
DEBOUNCE_CYCLES, 500_000, stable cycles required on BTN (optional feature only)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
BTN  in  1  raw push button; press = advance pattern
AUTO  in  1  1 = auto-advance after dwell enabled
pat_seg  in  8*NUM_PAT  segment bus of pattern i at [8i+7:8i], active-low
pat_an  in  4*NUM_PAT  anode bus of pattern i at [4i+3:4i], active-low
pat_step  out  NUM_PAT  one-hot, one-cycle step enable to the selected pattern
seg  out  8  display segments, active-low, registered
an  out  4  display anodes, active-low, registered
mode  out  $clog2(NUM_PAT)  index of the selected pattern

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values:
  - seg=8'hFF, an=4'hF, pat_step=0, mode=0
  - prescaler=0, dwell=0, blank counter=0
  - state=S_RUN
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where count==TICK_DIV-1.
  - Free-running in all states.
- FSM, states S_RUN and S_BLANK:
  - S_RUN:
    - pat_step[mode]=tick, other bits 0.
    - Registered output: seg<=pat_seg[mode], an<=pat_an[mode]. One-cycle latency from pat_* to pins.
    - On adv_req: mode<=(mode==NUM_PAT-1)?0:mode+1, dwell<=0, blank counter<=0, go to S_BLANK.
  - S_BLANK:
    - seg<=8'hFF, an<=4'hF, pat_step=0. Patterns freeze.
    - Blank counter increments each cycle.
    - At BLANK_CYCLES-1: go to S_RUN.
    - adv_req is ignored and dropped, not queued.
- Dwell counter:
  - Increments on tick in S_RUN only when AUTO=1.
  - Holds its value when AUTO=0.
  - auto_req=1 when tick && AUTO && dwell==DWELL_STEPS-1.
- Button path:
  - Two-flop synchronizer, then rising-edge detect gives btn_req (one cycle).
- adv_req=btn_req|auto_req. Simultaneous button and auto events advance mode by exactly one.
- Reset mid-blank or mid-dwell: immediate return to the reset values above. No residual pat_step pulse.
- Pattern FSMs are expected to hold state while their pat_step bit is 0.

Optional Feature:
FIDGET_SCHED_DEBOUNCE_EN
- Defined: the synchronized BTN must stay at a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level updates. The edge detect runs on the debounced level. Shorter glitches produce no btn_req.
- Undefined: no debounce. The edge detect runs directly on the synchronized BTN. DEBOUNCE_CYCLES is unused.

Decomposition:
- Package fidget_pkg holds:
  - sched_state_t enum {S_RUN, S_BLANK}
  - SEG_BLANK=8'hFF
  - AN_OFF=4'hF
- One sub-module, fidget_tick_gen: parameterized by TICK_DIV; ports CLK, RST, tick. Reused by other fidget blocks.
- Button sync, edge detect and debounce stay inline.

Test Plan:
All cases use NUM_PAT=3, TICK_DIV=4, DWELL_STEPS=3, BLANK_CYCLES=2, DEBOUNCE_CYCLES=3.
- Reset, then hold AUTO=0 and pat_seg[7:0]=8'h7F → seg=8'hFF in the first cycle. Afterwards seg=8'h7F one cycle after each change. pat_step[0] pulses every 4 cycles. mode stays 0.
- BTN 0→1 (held) → after sync plus edge, mode=1. seg=8'hFF and an=4'hF for exactly 2 cycles. Then pat_seg[1] is shown. No pat_step pulses during blank.
- AUTO=1, no BTN → mode advances 0→1→2→0. The advance fires on the 3rd tick in S_RUN of each pattern; this checks the wrap from 2 to 0.
- BTN edge in the same cycle as auto_req → mode advances by exactly 1. A second BTN edge during S_BLANK is ignored.
- RST asserted mid-S_BLANK with mode=2 → immediately mode=0, seg=8'hFF, an=4'hF, pat_step=0. After release, S_RUN resumes from pattern 0.
- With FIDGET_SCHED_DEBOUNCE_EN: a 2-cycle BTN glitch gives no advance; a 5-cycle press gives exactly one advance. Without the macro, the same 2-cycle glitch advances once.
